axi_xbar_nport: RTL

AXI_XBAR_NPORT -- requirements
Module: axi_xbar_nport

---
 rtl/axi_xbar_nport.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_xbar_nport.sv
// AXI4 1:N crossbar with address decode, per-slave narrow-access alignment
// and an internal DECERR responder. The read and write paths are
// independent, and each path has at most one transaction in flight.
module axi_xbar_nport #(
  parameter int                 NSLV      = 2,
  parameter int                 IDW       = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE  = {32'h0f00_0000, 32'h0200_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK  = {32'hffff_fe00, 32'hffff_0000},
  parameter logic [NSLV-1:0]    SLV_ALIGN = 2'b10
) (
  input  logic                           clk,
  input  logic                           rst,
  // upstream write address
  input  logic                           m_awvalid,
  output logic                           m_awready,
  input  logic [31:0]                    m_awaddr,
  input  logic [IDW-1:0]                 m_awid,
  input  logic [7:0]                     m_awlen,
  input  logic [2:0]                     m_awsize,
  input  logic [1:0]                     m_awburst,
  // upstream write data
  input  logic                           m_wvalid,
  output logic                           m_wready,
  input  logic [31:0]                    m_wdata,
  input  logic [3:0]                     m_wstrb,
  input  logic                           m_wlast,
  // upstream write response
  output logic                           m_bvalid,
  input  logic                           m_bready,
  output logic [1:0]                     m_bresp,
  output logic [IDW-1:0]                 m_bid,
  // upstream read address
  input  logic                           m_arvalid,
  output logic                           m_arready,
  input  logic [31:0]                    m_araddr,
  input  logic [IDW-1:0]                 m_arid,
  input  logic [7:0]                     m_arlen,
  input  logic [2:0]                     m_arsize,
  input  logic [1:0]                     m_arburst,
  // upstream read data
  output logic                           m_rvalid,
  input  logic                           m_rready,
  output logic [31:0]                    m_rdata,
  output logic [1:0]                     m_rresp,
  output logic [IDW-1:0]                 m_rid,
  output logic                           m_rlast,
  // downstream write address
  output logic [NSLV-1:0]                s_awvalid,
  input  logic [NSLV-1:0]                s_awready,
  output logic [NSLV-1:0][31:0]          s_awaddr,
  output logic [NSLV-1:0][IDW-1:0]       s_awid,
  output logic [NSLV-1:0][7:0]           s_awlen,
  output logic [NSLV-1:0][2:0]           s_awsize,
  output logic [NSLV-1:0][1:0]           s_awburst,
  // downstream write data
  output logic [NSLV-1:0]                s_wvalid,
  input  logic [NSLV-1:0]                s_wready,
  output logic [NSLV-1:0][31:0]          s_wdata,
  output logic [NSLV-1:0][3:0]           s_wstrb,
  output logic [NSLV-1:0]                s_wlast,
  // downstream write response
  input  logic [NSLV-1:0]                s_bvalid,
  output logic [NSLV-1:0]                s_bready,
  input  logic [NSLV-1:0][1:0]           s_bresp,
  input  logic [NSLV-1:0][IDW-1:0]       s_bid,
  // downstream read address
  output logic [NSLV-1:0]                s_arvalid,
  input  logic [NSLV-1:0]                s_arready,
  output logic [NSLV-1:0][31:0]          s_araddr,
  output logic [NSLV-1:0][IDW-1:0]       s_arid,
  output logic [NSLV-1:0][7:0]           s_arlen,
  output logic [NSLV-1:0][2:0]           s_arsize,
  output logic [NSLV-1:0][1:0]           s_arburst,
  // downstream read data
  input  logic [NSLV-1:0]                s_rvalid,
  output logic [NSLV-1:0]                s_rready,
  input  logic [NSLV-1:0][31:0]          s_rdata,
  input  logic [NSLV-1:0][1:0]           s_rresp,
  input  logic [NSLV-1:0][IDW-1:0]       s_rid,
  input  logic [NSLV-1:0]                s_rlast
);
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_e;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR} w_state_e;

  // Returns {miss, index}; the loop runs downward so the lowest hitting index wins.
  function automatic logic [SW:0] decode(input logic [31:0] a);
    logic [SW:0] res;
    res = {1'b1, {SW{1'b0}}};
    for (int i = NSLV - 1; i >= 0; i--)
      if ((a & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) res = {1'b0, SW'(i)};
    return res;
  endfunction

  r_state_e       r_state_q, r_state_d;
  logic [SW-1:0]  r_sel_q, r_sel_d;
  logic [1:0]     r_off_q, r_off_d;
  logic [IDW-1:0] r_id_q, r_id_d;
  logic [7:0]     r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic           r_acc_q, r_acc_d;   // DECERR read: address already accepted
  logic [SW:0]    r_dec;

  w_state_e       w_state_q, w_state_d;
  logic [SW-1:0]  w_sel_q, w_sel_d;
  logic [1:0]     w_off_q, w_off_d;
  logic [IDW-1:0] w_id_q, w_id_d;
  logic [1:0]     w_eph_q, w_eph_d;   // DECERR write phase: 0 aw, 1 w, 2 b
  logic [SW:0]    w_dec;

  // State registers for both paths; reset returns both FSMs to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE; r_sel_q <= '0; r_off_q <= '0; r_id_q <= '0;
      r_len_q <= '0; r_cnt_q <= '0; r_acc_q <= 1'b0;
      w_state_q <= W_IDLE; w_sel_q <= '0; w_off_q <= '0; w_id_q <= '0;
      w_eph_q <= '0;
    end else begin
      r_state_q <= r_state_d; r_sel_q <= r_sel_d; r_off_q <= r_off_d; r_id_q <= r_id_d;
      r_len_q <= r_len_d; r_cnt_q <= r_cnt_d; r_acc_q <= r_acc_d;
      w_state_q <= w_state_d; w_sel_q <= w_sel_d; w_off_q <= w_off_d; w_id_q <= w_id_d;
      w_eph_q <= w_eph_d;
    end
  end

  // Read path: decode, AR forwarding, R routing with realignment, DECERR beats.
  always_comb begin
    r_state_d = r_state_q; r_sel_d = r_sel_q; r_off_d = r_off_q; r_id_d = r_id_q;
    r_len_d = r_len_q; r_cnt_d = r_cnt_q; r_acc_d = r_acc_q;
    r_dec = decode(m_araddr);
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rid = '0; m_rlast = 1'b0;
    s_arvalid = '0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_rready = '0;
    case (r_state_q)
      R_IDLE: if (m_arvalid) begin
        r_sel_d = r_dec[SW-1:0]; r_off_d = m_araddr[1:0]; r_id_d = m_arid;
        r_len_d = m_arlen; r_cnt_d = '0; r_acc_d = 1'b0;
        r_state_d = r_dec[SW] ? R_ERR : R_ADDR;
      end
      R_ADDR: begin
        s_arvalid[r_sel_q] = m_arvalid;
        s_araddr[r_sel_q]  = SLV_ALIGN[r_sel_q] ? {m_araddr[31:2], 2'b00} : m_araddr;
        s_arid[r_sel_q]    = m_arid;
        s_arlen[r_sel_q]   = m_arlen;
        s_arsize[r_sel_q]  = m_arsize;
        s_arburst[r_sel_q] = m_arburst;
        m_arready = s_arready[r_sel_q];
        if (m_arvalid && s_arready[r_sel_q]) r_state_d = R_DATA;
      end
      R_DATA: begin
        m_rvalid = s_rvalid[r_sel_q];
        m_rdata  = SLV_ALIGN[r_sel_q] ? (s_rdata[r_sel_q] >> {r_off_q, 3'b000}) : s_rdata[r_sel_q];
        m_rresp  = s_rresp[r_sel_q];
        m_rid    = s_rid[r_sel_q];
        m_rlast  = s_rlast[r_sel_q];
        s_rready[r_sel_q] = m_rready;
        if (s_rvalid[r_sel_q] && m_rready && s_rlast[r_sel_q]) r_state_d = R_IDLE;
      end
      R_ERR: begin
        if (!r_acc_q) begin
          m_arready = 1'b1;
          if (m_arvalid) r_acc_d = 1'b1;
        end else begin
          m_rvalid = 1'b1; m_rresp = 2'b11; m_rid = r_id_q;
          m_rlast  = (r_cnt_q == r_len_q);
          if (m_rready) begin
            r_cnt_d = r_cnt_q + 8'd1;
            if (r_cnt_q == r_len_q) r_state_d = R_IDLE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write path: the selected lane is held from AW through the B handshake.
  always_comb begin
    w_state_d = w_state_q; w_sel_d = w_sel_q; w_off_d = w_off_q; w_id_d = w_id_q;
    w_eph_d = w_eph_q;
    w_dec = decode(m_awaddr);
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0; m_bid = '0;
    s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_bready = '0;
    case (w_state_q)
      W_IDLE: if (m_awvalid) begin
        w_sel_d = w_dec[SW-1:0]; w_off_d = m_awaddr[1:0]; w_id_d = m_awid; w_eph_d = '0;
        w_state_d = w_dec[SW] ? W_ERR : W_ADDR;
      end
      W_ADDR: begin
        s_awvalid[w_sel_q] = m_awvalid;
        s_awaddr[w_sel_q]  = SLV_ALIGN[w_sel_q] ? {m_awaddr[31:2], 2'b00} : m_awaddr;
        s_awid[w_sel_q]    = m_awid;
        s_awlen[w_sel_q]   = m_awlen;
        s_awsize[w_sel_q]  = m_awsize;
        s_awburst[w_sel_q] = m_awburst;
        m_awready = s_awready[w_sel_q];
        if (m_awvalid && s_awready[w_sel_q]) w_state_d = W_DATA;
      end
      W_DATA: begin
        s_wvalid[w_sel_q] = m_wvalid;
        s_wdata[w_sel_q]  = SLV_ALIGN[w_sel_q] ? (m_wdata << {w_off_q, 3'b000}) : m_wdata;
        s_wstrb[w_sel_q]  = SLV_ALIGN[w_sel_q] ? (m_wstrb << w_off_q) : m_wstrb;
        s_wlast[w_sel_q]  = m_wlast;
        m_wready = s_wready[w_sel_q];
        if (m_wvalid && s_wready[w_sel_q] && m_wlast) w_state_d = W_RESP;
      end
      W_RESP: begin
        m_bvalid = s_bvalid[w_sel_q];
        m_bresp  = s_bresp[w_sel_q];
        m_bid    = s_bid[w_sel_q];
        s_bready[w_sel_q] = m_bready;
        if (s_bvalid[w_sel_q] && m_bready) w_state_d = W_IDLE;
      end
      W_ERR: begin
        case (w_eph_q)
          2'd0: begin
            m_awready = 1'b1;
            if (m_awvalid) w_eph_d = 2'd1;
          end
          2'd1: begin
            m_wready = 1'b1;
            if (m_wvalid && m_wlast) w_eph_d = 2'd2;
          end
          default: begin
            m_bvalid = 1'b1; m_bresp = 2'b11; m_bid = w_id_q;
            if (m_bready) w_state_d = W_IDLE;
          end
        endcase
      end
      default: w_state_d = W_IDLE;
    endcase
  end
endmodule
